// File: rtl/mem_access_unit.sv
// Load/store stage ahead of the data RAM: one request at a time, big-endian
// lane steering, load extension, alignment check, LL/SC link bit and flush.
module mem_access_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [REG_W-1:0]  req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [REG_W-1:0]  resp_rd,
  output logic              resp_we,
  output logic              resp_exc,
  output logic [ADDR_W-1:0] resp_badaddr,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_sel,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              llbit
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [REG_W-1:0]    r_rd;
  logic                r_llbit;
  logic [31:0]         r_resp_data;
  logic [REG_W-1:0]    r_resp_rd;
  logic                r_resp_we;
  logic                r_resp_exc;
  logic [ADDR_W-1:0]   r_resp_badaddr;

  logic        w_load, w_store, w_sc, w_ll, w_rsvd, w_byte, w_half, w_word, w_mis;
  logic        w_go, w_ce;
  logic [3:0]  w_sel;
  logic [31:0] w_wrep, w_ldata, w_rdata;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_rwe, w_rexc;

  always_comb begin
    w_load  = (r_op <= 4'd4) || (r_op == 4'd8);
    w_store = (r_op >= 4'd5) && (r_op <= 4'd7);
    w_sc    = (r_op == 4'd9);
    w_ll    = (r_op == 4'd8);
    w_rsvd  = (r_op >= 4'd10);
    w_byte  = (r_op == 4'd0) || (r_op == 4'd1) || (r_op == 4'd5);
    w_half  = (r_op == 4'd2) || (r_op == 4'd3) || (r_op == 4'd6);
    w_word  = !w_rsvd && !w_byte && !w_half;
    w_mis   = (w_half && r_addr[0]) || (w_word && (r_addr[1:0] != 2'b00));

    w_sel  = '0;
    w_wrep = r_wdata;
    if (w_byte) begin
      w_sel  = 4'b1000 >> r_addr[1:0];
      w_wrep = {4{r_wdata[7:0]}};
    end else if (w_half) begin
      w_sel  = r_addr[1] ? 4'b0011 : 4'b1100;
      w_wrep = {2{r_wdata[15:0]}};
    end else if (w_word) begin
      w_sel  = 4'b1111;
    end

    // Offset 0 is the most significant lane (big-endian).
    case (r_addr[1:0])
      2'd0:    w_b = ram_rdata[31:24];
      2'd1:    w_b = ram_rdata[23:16];
      2'd2:    w_b = ram_rdata[15:8];
      default: w_b = ram_rdata[7:0];
    endcase
    w_h = r_addr[1] ? ram_rdata[15:0] : ram_rdata[31:16];

    case (r_op)
      4'd0:    w_ldata = {{24{w_b[7]}}, w_b};
      4'd1:    w_ldata = {24'd0, w_b};
      4'd2:    w_ldata = {{16{w_h[15]}}, w_h};
      4'd3:    w_ldata = {16'd0, w_h};
      default: w_ldata = ram_rdata;
    endcase

    w_go = (r_state == S_ACCESS) && !flush;
    w_ce = w_go && !w_rsvd && !w_mis && !(w_sc && !r_llbit);

    w_rdata = '0;
    w_rwe   = 1'b0;
    w_rexc  = 1'b0;
    if (!w_rsvd) begin
      if (w_mis) begin
        w_rexc = 1'b1;
      end else if (w_load) begin
        w_rdata = w_ldata;
        w_rwe   = 1'b1;
      end else if (w_sc) begin
        w_rdata = {31'd0, r_llbit};
        w_rwe   = 1'b1;
      end
    end
  end

  assign ram_ce    = w_ce;
  assign ram_we    = w_ce && (w_store || w_sc);
  assign ram_addr  = (r_state == S_ACCESS) ? r_addr : '0;
  assign ram_sel   = (r_state == S_ACCESS) ? w_sel  : '0;
  assign ram_wdata = (r_state == S_ACCESS) ? w_wrep : '0;

  assign req_ready    = (r_state == S_IDLE) && !flush;
  assign resp_valid   = (r_state == S_RESP);
  assign resp_data    = r_resp_data;
  assign resp_rd      = r_resp_rd;
  assign resp_we      = r_resp_we;
  assign resp_exc     = r_resp_exc;
  assign resp_badaddr = r_resp_badaddr;
  assign llbit        = r_llbit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid && req_ready) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rd           <= '0;
      r_llbit        <= 1'b0;
      r_resp_data    <= '0;
      r_resp_rd      <= '0;
      r_resp_we      <= 1'b0;
      r_resp_exc     <= 1'b0;
      r_resp_badaddr <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid && req_ready) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rd    <= req_rd;
      end
      if (w_go) begin
        r_resp_data    <= w_rdata;
        r_resp_rd      <= r_rd;
        r_resp_we      <= w_rwe;
        r_resp_exc     <= w_rexc;
        r_resp_badaddr <= w_rexc ? r_addr : '0;
      end
      // Flush beats a same-cycle LL set.
      if (flush)
        r_llbit <= 1'b0;
      else if (w_go && !w_mis && w_ll)
        r_llbit <= 1'b1;
      else if (w_go && !w_mis && w_sc)
        r_llbit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan cases plus random ops against a
// transaction-level model of memory contents and the link bit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic        resp_exc;
  logic [31:0] resp_badaddr;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        llbit;

  mem_access_unit #(.ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_we(resp_we), .resp_exc(resp_exc),
    .resp_badaddr(resp_badaddr),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .llbit(llbit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram_mem   [0:63];
  logic [31:0] model_mem [0:63];
  bit          model_ll = 1'b0;
  bit          in_access = 1'b0;

  logic [31:0] last_data, last_bad, last_rwdata;
  logic [3:0]  last_sel;
  logic        last_ce, last_we, last_exc;

  assign ram_rdata = ram_mem[ram_addr[7:2]];

  always @(posedge clk)
    if (ram_ce && ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) ram_mem[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Outside the access cycle the RAM must never be enabled.
  always @(negedge clk) begin
    #2;
    if (!in_access) begin
      chk("ram_ce_idle", {31'd0, ram_ce}, 32'd0);
      chk("ram_we_idle", {31'd0, ram_we}, 32'd0);
    end
  end

  task automatic set_word(input int unsigned idx, input logic [31:0] w);
    ram_mem[idx]   = w;
    model_mem[idx] = w;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input bit fl, input int unsigned hold);
    int unsigned b, size;
    logic [31:0] word, v, wrep, e_data, e_bad;
    logic [3:0]  sel;
    bit is_load, is_store, sc, rsvd, mis, e_ce, e_wram, e_we, e_exc;

    b        = int'(addr % 4);
    word     = model_mem[addr[7:2]];
    is_load  = (op <= 4) || (op == 8);
    is_store = (op >= 5) && (op <= 7);
    sc       = (op == 9);
    rsvd     = (op >= 10);
    size     = (op == 0 || op == 1 || op == 5) ? 1 : (op == 2 || op == 3 || op == 6) ? 2 : 4;
    mis      = !rsvd && ((size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0));
    e_ce     = !rsvd && !mis && !(sc && !model_ll) && !fl;
    e_wram   = e_ce && (is_store || sc);
    if (size == 1) begin
      sel  = 4'(1 << (3 - b));
      wrep = (wdata & 32'hFF) * 32'h01010101;
      v    = (word >> (8 * (3 - b))) & 32'hFF;
      if (op == 0 && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2) begin
      sel  = (b < 2) ? 4'hC : 4'h3;
      wrep = (wdata & 32'hFFFF) * 32'h00010001;
      v    = (word >> ((b < 2) ? 16 : 0)) & 32'hFFFF;
      if (op == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      sel  = 4'hF;
      wrep = wdata;
      v    = word;
    end
    e_data = 0; e_we = 0; e_exc = 0; e_bad = 0;
    if (rsvd) begin
    end else if (mis) begin
      e_exc = 1; e_bad = addr;
    end else if (is_load) begin
      e_we = 1; e_data = v;
    end else if (sc) begin
      e_we = 1; e_data = model_ll ? 32'd1 : 32'd0;
    end

    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    #1 chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 0; req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    in_access = 1; flush = fl;
    #1;
    last_ce = ram_ce; last_we = ram_we; last_sel = ram_sel; last_rwdata = ram_wdata;
    chk("access_ce", {31'd0, ram_ce}, {31'd0, e_ce});
    chk("access_we", {31'd0, ram_we}, {31'd0, e_wram});
    chk("access_req_ready", {31'd0, req_ready}, 32'd0);
    if (e_ce) begin
      chk("access_addr", ram_addr, addr);
      chk("access_sel", {28'd0, ram_sel}, {28'd0, sel});
      chk("access_wdata", ram_wdata, wrep);
    end
    @(posedge clk);
    #1 flush = 0; in_access = 0;

    if (fl) begin
      model_ll = 0;
    end else begin
      if (e_wram) begin
        for (int i = 0; i < 4; i++) if (sel[i]) word[8*i +: 8] = wrep[8*i +: 8];
        model_mem[addr[7:2]] = word;
      end
      if (!mis && op == 8) model_ll = 1;
      if (!mis && sc) model_ll = 0;
    end

    if (fl) begin
      @(negedge clk);
      chk("flush_no_resp", {31'd0, resp_valid}, 32'd0);
    end else begin
      for (int unsigned i = 0; i <= hold; i++) begin
        @(negedge clk);
        if (i == 0) begin
          last_data = resp_data; last_exc = resp_exc; last_bad = resp_badaddr;
        end
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_data", resp_data, e_data);
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        chk("resp_we", {31'd0, resp_we}, {31'd0, e_we});
        chk("resp_exc", {31'd0, resp_exc}, {31'd0, e_exc});
        chk("resp_badaddr", resp_badaddr, e_bad);
        chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
        if (i == hold) resp_ready = 1;
        @(posedge clk);
        #1 resp_ready = 0;
      end
    end
    @(negedge clk);
    chk("after_valid", {31'd0, resp_valid}, 32'd0);
    chk("after_ready", {31'd0, req_ready}, 32'd1);
    chk("llbit", {31'd0, llbit}, {31'd0, model_ll});
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1;
    #1 chk("flush_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 0;
    model_ll = 0;
    chk("flush_llbit", {31'd0, llbit}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_word(i, $urandom);
    #3;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_we", {31'd0, resp_we}, 32'd0);
    chk("rst_ram_ce", {31'd0, ram_ce}, 32'd0);
    chk("rst_ram_sel", {28'd0, ram_sel}, 32'd0);
    chk("rst_llbit", {31'd0, llbit}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1;

    set_word(4, 32'h11223344);
    do_op(4'd4, 32'h10, 32'h0, 5'd3, 0, 0);
    chk("lit_lw", last_data, 32'h11223344);
    chk("lit_lw_sel", {28'd0, last_sel}, 32'hF);

    set_word(4, 32'h80FF7F81);
    do_op(4'd0, 32'h13, 32'h0, 5'd4, 0, 0); chk("lit_lb13", last_data, 32'hFFFFFF81);
    do_op(4'd1, 32'h13, 32'h0, 5'd5, 0, 0); chk("lit_lbu13", last_data, 32'h00000081);
    do_op(4'd0, 32'h10, 32'h0, 5'd6, 0, 0); chk("lit_lb10", last_data, 32'hFFFFFF80);
    do_op(4'd2, 32'h12, 32'h0, 5'd7, 0, 0); chk("lit_lh12", last_data, 32'h00007F81);

    do_op(4'd5, 32'h11, 32'hAB, 5'd1, 0, 0);
    chk("lit_sb_sel", {28'd0, last_sel}, 32'h4);
    chk("lit_sb_wdata", last_rwdata, 32'hABABABAB);
    chk("lit_sb_we", {31'd0, last_we}, 32'd1);
    do_op(4'd6, 32'h12, 32'h1234, 5'd1, 0, 0);
    chk("lit_sh_sel", {28'd0, last_sel}, 32'h3);
    chk("lit_sh_wdata", last_rwdata, 32'h12341234);

    do_op(4'd4, 32'h12, 32'h0, 5'd2, 0, 0);
    chk("lit_mis_lw_ce", {31'd0, last_ce}, 32'd0);
    chk("lit_mis_lw_exc", {31'd0, last_exc}, 32'd1);
    chk("lit_mis_lw_bad", last_bad, 32'h12);
    do_op(4'd2, 32'h11, 32'h0, 5'd2, 0, 0);
    chk("lit_mis_lh_exc", {31'd0, last_exc}, 32'd1);
    chk("lit_mis_lh_bad", last_bad, 32'h11);

    do_op(4'd8, 32'h20, 32'h0, 5'd8, 0, 0);
    chk("lit_ll_bit", {31'd0, llbit}, 32'd1);
    do_op(4'd9, 32'h20, 32'd5, 5'd9, 0, 0);
    chk("lit_sc1_data", last_data, 32'd1);
    chk("lit_sc1_mem", ram_mem[8], 32'd5);
    chk("lit_sc1_ll", {31'd0, llbit}, 32'd0);
    do_op(4'd9, 32'h20, 32'd6, 5'd9, 0, 0);
    chk("lit_sc2_ce", {31'd0, last_ce}, 32'd0);
    chk("lit_sc2_data", last_data, 32'd0);

    do_op(4'd8, 32'h20, 32'h0, 5'd8, 0, 0);
    flush_pulse();
    do_op(4'd9, 32'h20, 32'd7, 5'd9, 0, 0);
    chk("lit_sc_flushed", last_data, 32'd0);

    do_op(4'd7, 32'h24, 32'hCAFEF00D, 5'd1, 1, 0);
    chk("lit_sw_flush_we", {31'd0, last_we}, 32'd0);
    do_op(4'd4, 32'h28, 32'h0, 5'd11, 0, 3);
    do_op(4'd12, 32'h2C, 32'h0, 5'd12, 0, 1);

    // Reset in the middle of a store access: the write must be dropped.
    do_op(4'd8, 32'h30, 32'h0, 5'd8, 0, 0);
    @(negedge clk);
    req_valid = 1; req_op = 4'd7; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    in_access = 1;
    #1 chk("rstmid_we_before", {31'd0, ram_we}, 32'd1);
    rst = 0;
    #1 chk("rstmid_we_after", {31'd0, ram_we}, 32'd0);
    chk("rstmid_llbit", {31'd0, llbit}, 32'd0);
    @(posedge clk);
    #1 in_access = 0; rst = 1;
    model_ll = 0;
    chk("rstmid_mem", ram_mem[16], model_mem[16]);

    for (int n = 0; n < 300; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 10));
      if (($urandom % 4) == 0) op = 4'($urandom_range(8, 9));
      a  = {($urandom_range(0, 3) == 0) ? 24'hA5A5A5 : 24'h0, 8'($urandom_range(0, 63))};
      if (($urandom % 2) == 0) a[1:0] = 2'b00;
      do_op(op, a, $urandom, 5'($urandom), ($urandom % 10) == 0, $urandom_range(0, 2));
      if (($urandom % 20) == 0) flush_pulse();
    end

    for (int i = 0; i < 64; i++) chk("final_mem", ram_mem[i], model_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage that sits directly upstream of the data RAM.
- Accepts one memory request at a time from the pipeline over a valid/ready handshake and drives the RAM's ce/we/addr/sel/wdata.
- Extracts and extends load data from the RAM's combinational read port and returns a registered response for register write-back.
- Also checks alignment, maintains the LL/SC link bit, and supports flush on exception.

Parameters:
- ADDR_W, 32, byte-address width of req_addr/ram_addr.
- REG_W, 5, width of the destination register tag.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  exception flush: abort in-flight op, clear link bit.
- req_valid  input  1  request valid.
- req_ready  output  1  unit can accept a request.
- req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC; 10-15 reserved.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- req_rd  input  REG_W  destination register tag.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts response.
- resp_data  output  32  extended load data, or SC result.
- resp_rd  output  REG_W  echoed req_rd.
- resp_we  output  1  response writes a GPR.
- resp_exc  output  1  address-alignment exception.
- resp_badaddr  output  ADDR_W  faulting address; 0 when resp_exc=0.
- ram_ce  output  1  RAM chip enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM byte address.
- ram_sel  output  4  byte-lane enables; bit3 = data[31:24].
- ram_wdata  output  32  lane-replicated store data.
- ram_rdata  input  32  combinational RAM read data.
- llbit  output  1  current link bit.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, llbit=0.
  - All resp_* outputs = 0.
  - Latched request fields = 0.
  - ram_* outputs = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = !flush.
  - On req_valid & req_ready, latch op/addr/wdata/rd and go to ACCESS.
- ACCESS (exactly one cycle):
  - ram_* outputs are driven combinationally from the latched fields; they are 0 in every other state.
  - resp_* registers load at the end of the cycle; next state is RESP.
- RESP:
  - resp_valid=1; all resp_* outputs hold stable until resp_ready=1, then go to IDLE.
  - resp_valid deasserts the cycle after the handshake.
- Latency: request accepted at edge N; RAM accessed during cycle N+1; resp_valid=1 from edge N+1. Maximum throughput is 1 op per 3 cycles.
- Byte order is big-endian. Byte offset addr[1:0]=0 maps to lane 3.
  - Byte ops: sel = 4'b1000 >> addr[1:0].
  - Half ops: sel = 4'b1100 (addr[1]=0) or 4'b0011 (addr[1]=1).
  - Word ops: sel = 4'b1111.
- Store lane replication: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW/SC → wdata.
- Load extraction:
  - The selected lane(s) of ram_rdata are right-justified.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW/LL take the full word.
  - Load responses set resp_we=1.
- Store responses (SB/SH/SW) set resp_we=0 and resp_data=0.
- Misalignment:
  - Condition: half op with addr[0]=1, or word op (LW/SW/LL/SC) with addr[1:0]≠0.
  - In ACCESS: ram_ce=0 (no access).
  - Response: resp_exc=1, resp_badaddr=addr, resp_we=0, resp_data=0.
  - llbit is unchanged.
- LL: behaves as LW; sets llbit=1 at the end of ACCESS.
- SC:
  - llbit=1: perform the word store; resp_data=1.
  - llbit=0: ram_ce=0; resp_data=0.
  - Either way resp_we=1 and llbit is cleared at the end of ACCESS.
- Reserved ops: no RAM access; response with resp_we=0, resp_exc=0, resp_data=0.
- flush=1 (any state):
  - llbit cleared at the clock edge.
  - In ACCESS, ram_ce and ram_we are forced to 0 in that cycle, so no write occurs.
  - State returns to IDLE and resp_valid is cleared.
  - A flush coinciding with a link-bit set by LL wins (llbit=0).
- Reset asserted mid-operation: immediate return to reset values; any in-flight write is dropped.

Test Plan:
- LW at 0x10, RAM word 0x11223344 → ram_sel=1111, resp_data=0x11223344, resp_we=1, resp_valid at edge N+1.
- LB at 0x13 and 0x10 with word 0x80FF7F81:
  - LB 0x13 → 0xFFFFFF81.
  - LBU 0x13 → 0x00000081.
  - LB 0x10 → 0xFFFFFF80.
  - LH 0x12 → 0x00007F81.
- SB at 0x11, wdata 0xAB → ram_sel=0100, ram_wdata=0xABABABAB, ram_we=1 for one cycle; SH 0x12, wdata 0x1234 → sel=0011, wdata=0x12341234.
- LW at 0x12 → ram_ce never 1, resp_exc=1, resp_badaddr=0x12, resp_we=0; LH at 0x11 gives the same exception response.
- LL 0x20, then SC 0x20 with wdata 5 → store occurs, resp_data=1, llbit=0; second SC → no ram_ce, resp_data=0.
- LL, then flush pulse, then SC → resp_data=0. SW with flush asserted in ACCESS → ram_we stays 0 and no response. Hold resp_ready=0 for 3 cycles → resp_* stable and req_ready=0.
